// File: rtl/aes_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_loader_pkg
// Brief    : Shared types, widths and helpers for the AES block loader.
// Revision : 1.0 - initial release
// ============================================================================
package aes_loader_pkg;

  // Loader phases: collect words, wait on the core, enforce idle gap.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  // Width needed for a counter that must hold the larger of two limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_block_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_loader_if
// Brief    : Upstream word stream plus AES core launch/complete signals.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_block_loader_if;
  import aes_loader_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_word;
  logic                in_sel;
  logic                AES_data_out_valid;
  logic                AES_en;
  logic [BLOCK_W-1:0]  AES_data_in;
  logic [BLOCK_W-1:0]  AES_key_in;

  // The loader side.
  modport slave (
    input  in_valid, in_word, in_sel, AES_data_out_valid,
    output in_ready, AES_en, AES_data_in, AES_key_in
  );

  // The system side: word source and AES core.
  modport master (
    output in_valid, in_word, in_sel, AES_data_out_valid,
    input  in_ready, AES_en, AES_data_in, AES_key_in
  );
endinterface
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : aes_word_packer
// Brief    : Packs four 32-bit words into a 128-bit slot register; first
//            word lands in the top slot. Full behaviour is selectable:
//            restart a new load, or discard and report a drop.
// Revision : 1.0 - initial release
// ============================================================================
module aes_word_packer
  import aes_loader_pkg::*;
#(
  parameter bit RELOAD_ON_FULL = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic               restart_i,
  output logic [BLOCK_W-1:0] block_o,
  output logic               full_o,
  output logic               drop_o
);

  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] slot_q;
  logic [1:0]                             cnt_q;
  logic                                   full_q;

  // Slot writes, counter advance and full-flag handling.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q <= '0;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else if (restart_i) begin
      // Slots keep their contents so the outputs stay frozen while running.
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else if (wr_en_i) begin
      if (full_q) begin
        if (RELOAD_ON_FULL) begin
          slot_q[0] <= word_i;
          cnt_q     <= 2'd1;
          full_q    <= 1'b0;
        end
      end else begin
        slot_q[cnt_q] <= word_i;
        cnt_q         <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) full_q <= 1'b1;
      end
    end
  end

  // Slot 0 is the most significant word of the packed block.
  for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_pack
    assign block_o[BLOCK_W-1-gi*WORD_W -: WORD_W] = slot_q[gi];
  end

  assign full_o = full_q;
  assign drop_o = wr_en_i & full_q & ~RELOAD_ON_FULL;

endmodule
`default_nettype wire

// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_loader
// Brief    : Feeds the AES core: packs key/data words, launches a block,
//            waits for completion or timeout, then enforces an idle gap.
//            The key stays loaded across blocks.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2
) (
  input  logic                AES_clk,
  input  logic                AES_rst,
  aes_block_loader_if.slave   bus,
  input  logic                err_clr,
  output logic                busy,
  output logic                timeout_err,
  output logic                drop_err
);

  localparam int             CW         = cnt_width(TIMEOUT_CYC, GAP_CYC);
  localparam logic [CW-1:0]  c_RUN_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  c_GAP_LAST = CW'(GAP_CYC - 1);

  state_e         state_q;
  logic           en_q;
  logic           busy_q;
  logic           terr_q, terr_d;
  logic           derr_q, derr_d;
  logic [CW-1:0]  run_cnt_q;
  logic [CW-1:0]  gap_cnt_q;

  logic w_hs, w_key_wr, w_data_wr;
  logic w_key_full, w_data_full, w_key_drop, w_data_drop;
  logic w_launch, w_timeout;

  assign bus.in_ready = (state_q == ST_FILL);
  assign w_hs         = bus.in_valid & bus.in_ready;
  assign w_key_wr     = w_hs &  bus.in_sel;
  assign w_data_wr    = w_hs & ~bus.in_sel;
  assign w_launch     = (state_q == ST_FILL) & w_key_full & w_data_full;
  // Completion on the final counted cycle takes priority over timeout.
  assign w_timeout    = (state_q == ST_RUN) & ~bus.AES_data_out_valid &
                        (run_cnt_q == c_RUN_LAST);

  // A new key word on a full key starts a fresh key load.
  aes_word_packer #(.RELOAD_ON_FULL(1'b1)) u_key (
    .clk_i     (AES_clk),
    .rst_i     (AES_rst),
    .wr_en_i   (w_key_wr),
    .word_i    (bus.in_word),
    .restart_i (1'b0),
    .block_o   (bus.AES_key_in),
    .full_o    (w_key_full),
    .drop_o    (w_key_drop)
  );

  // Data clears on launch; extra words on a full block are dropped.
  aes_word_packer #(.RELOAD_ON_FULL(1'b0)) u_data (
    .clk_i     (AES_clk),
    .rst_i     (AES_rst),
    .wr_en_i   (w_data_wr),
    .word_i    (bus.in_word),
    .restart_i (w_launch),
    .block_o   (bus.AES_data_in),
    .full_o    (w_data_full),
    .drop_o    (w_data_drop)
  );

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_comb begin
    terr_d = w_timeout | (terr_q & ~err_clr);
    derr_d = w_key_drop | w_data_drop | (derr_q & ~err_clr);
  end

  // Phase sequencing with registered enable, busy and error outputs.
  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q   <= ST_FILL;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
      derr_q    <= 1'b0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      terr_q <= terr_d;
      derr_q <= derr_d;
      case (state_q)
        ST_FILL: begin
          if (w_launch) begin
            state_q   <= ST_RUN;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            run_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (bus.AES_data_out_valid || (run_cnt_q == c_RUN_LAST)) begin
            state_q   <= ST_GAP;
            en_q      <= 1'b0;
            gap_cnt_q <= '0;
          end else begin
            run_cnt_q <= run_cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == c_GAP_LAST) begin
            state_q <= ST_FILL;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_FILL;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.AES_en  = en_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign drop_err    = derr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_loader
// Brief    : Scoreboard bench for aes_block_loader; expected launches are
//            queued by the stimulus and checked by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_loader;

  localparam int GAP = 2;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    int           run_len;
    logic         terr;
    bit           chk_len;
  } exp_t;

  logic clk;
  logic rst;
  logic err_clr;
  logic busy, timeout_err, drop_err;
  int   checks = 0;
  int   errors = 0;
  int   valid_at = 1000;
  int   run_idx = 0;
  exp_t sb_q[$];

  aes_block_loader_if bus ();

  aes_block_loader #(.TIMEOUT_CYC(64), .GAP_CYC(GAP)) dut (
    .AES_clk     (clk),
    .AES_rst     (rst),
    .bus         (bus.slave),
    .err_clr     (err_clr),
    .busy        (busy),
    .timeout_err (timeout_err),
    .drop_err    (drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // AES core model: raise completion on RUN cycle valid_at.
  always @(negedge clk) begin
    if (bus.AES_en) begin
      bus.AES_data_out_valid = (run_idx == valid_at);
      run_idx++;
    end else begin
      bus.AES_data_out_valid = 1'b0;
      run_idx = 0;
    end
  end

  // Monitor: checks each launch, its run length and the following gap.
  exp_t cur;
  bit   prev_en = 1'b0;
  bit   have = 1'b0;
  bit   in_gap = 1'b0;
  int   run_len = 0;
  int   gap_len = 0;
  always @(negedge clk) begin
    if (bus.AES_en && !prev_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got launch data %h expected none", bus.AES_data_in);
        have = 1'b0;
      end else begin
        cur  = sb_q.pop_front();
        have = 1'b1;
        chk("launch_key", bus.AES_key_in, cur.key);
        chk("launch_data", bus.AES_data_in, cur.data);
      end
      run_len = 1;
    end else if (bus.AES_en) begin
      run_len++;
    end else if (prev_en) begin
      if (have && cur.chk_len) begin
        chk("run_len", 128'(run_len), 128'(cur.run_len));
        chk("timeout_err_at_end", 128'(timeout_err), 128'(cur.terr));
        in_gap  = 1'b1;
        gap_len = 1;
      end
      have = 1'b0;
    end else if (in_gap) begin
      if (busy) gap_len++;
      else begin
        chk("gap_len", 128'(gap_len), 128'(GAP));
        chk("in_ready_after_gap", 128'(bus.in_ready), 128'(1));
        in_gap = 1'b0;
      end
    end
    prev_en = bus.AES_en;
  end

  task automatic send(input logic sel, input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_word  = w;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait: got in_ready 0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send4(input logic sel, input logic [127:0] blk);
    logic [127:0] b;
    b = blk;
    for (int i = 0; i < 4; i++) send(sel, b[127-32*i -: 32]);
  endtask

  task automatic wait_busy(input logic lvl, input int bound);
    int n = 0;
    @(negedge clk);
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_busy: got busy %b expected %b within %0d cycles", busy, lvl, bound);
    end
  endtask

  task automatic push(input logic [127:0] k, input logic [127:0] d, input int len,
                      input logic te, input bit cl);
    exp_t e;
    e.key = k; e.data = d; e.run_len = len; e.terr = te; e.chk_len = cl;
    sb_q.push_back(e);
  endtask

  localparam logic [127:0] KEY1 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] DAT1 = 128'h00000092_00000000_00000000_00000000;
  localparam logic [127:0] DAT2 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] DAT3 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] DAT5 = 128'h0badf00d_deadbeef_cafebabe_12345678;
  localparam logic [127:0] DAT4 = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
  localparam logic [127:0] KEY4 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  initial begin
    rst = 1'b1;
    err_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel = 1'b0;
    bus.in_word = '0;
    bus.AES_data_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", 128'(bus.AES_en), 128'(0));
    chk("rst_data", bus.AES_data_in, 128'(0));
    chk("rst_key", bus.AES_key_in, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_errs", 128'({timeout_err, drop_err}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));

    // Single block, completion on RUN cycle 40.
    valid_at = 40;
    push(KEY1, DAT1, 41, 1'b0, 1'b1);
    send4(1'b1, KEY1);
    send4(1'b0, DAT1);
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 200);

    // Key reuse with data only.
    push(KEY1, DAT2, 41, 1'b0, 1'b1);
    send4(1'b0, DAT2);
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 200);

    // Timeout: core never completes.
    valid_at = 1000;
    push(KEY1, DAT3, 64, 1'b1, 1'b1);
    send4(1'b0, DAT3);
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 200);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 128'(timeout_err), 128'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout_cleared", 128'(timeout_err), 128'(0));

    // Reset while running.
    push(KEY1, DAT5, 0, 1'b0, 1'b0);
    send4(1'b0, DAT5);
    wait_busy(1'b1, 5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_en", 128'(bus.AES_en), 128'(0));
    chk("rstrun_data", bus.AES_data_in, 128'(0));
    chk("rstrun_key", bus.AES_key_in, 128'(0));
    chk("rstrun_key_full", 128'(dut.w_key_full), 128'(0));

    // Data before any key, overflow word, then key completes the set.
    valid_at = 40;
    send4(1'b0, DAT4);
    repeat (3) @(negedge clk);
    chk("data_only_no_launch", 128'({busy, bus.AES_en}), 128'(0));
    send(1'b0, 32'hf301a68a);
    @(negedge clk);
    chk("drop_err_set", 128'(drop_err), 128'(1));
    chk("data_unchanged", bus.AES_data_in, DAT4);
    push(KEY4, DAT4, 41, 1'b0, 1'b1);
    send4(1'b1, KEY4);
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 200);
    repeat (2) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("drop_cleared", 128'(drop_err), 128'(0));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
